fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests words from instruction memory, holds the
// issued instruction, and advances the PC (sequential or beq/bne) once it resolves.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  BEQ_OP   = 6'b000100,
  parameter logic [5:0]  BNE_OP   = 6'b000101
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        ex_done,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    ISSUE = 2'b10,
    WAIT  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        capture_s;
  logic        taken_s;
  logic [31:0] offset_s;

  // Next-state, capture and PC update logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    valid_d   = 1'b0;
    capture_s = (state_q == FETCH) & req_q & imem_ready & ~stall;
    taken_s   = branch & (((instr_q[31:26] == BEQ_OP) & zero) |
                          ((instr_q[31:26] == BNE_OP) & ~zero));
    offset_s  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (capture_s) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = ISSUE;
        end else begin
          state_d  = FETCH;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (ex_done) begin
          if (taken_s) begin
            pc_d = pc_q + 32'd4 + offset_s;
          end else begin
            pc_d = pc_q + 32'd4;
          end
          state_d = FETCH;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The first FETCH cycle after reset issues no request, so it appears on the second edge.
    req_d = (state_d == FETCH) & ~stall & (state_q != IDLE);
  end

  // State and registered outputs, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0000_0000;
      pc_out_q <= RESET_PC;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural fetch/issue/resolve model compared
// every cycle, directed scenarios with literal expectations, then random stimulus.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        ex_done = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_out;
  logic        instr_valid;

  int n_checks = 0;
  int n_pass   = 0;
  int vcount   = 0;

  // Behavioural model: where the unit is in its fetch -> issue -> resolve cycle
  localparam int PH_START = 0, PH_MEM = 1, PH_ISSUED = 2, PH_EXEC = 3;
  int          m_phase = PH_START;
  logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_pc_out = 32'h0;
  logic        m_req = 1'b0, m_valid = 1'b0;

  logic [31:0] a;
  logic [31:0] r;
  int          v0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .ex_done(ex_done), .branch(branch), .zero(zero), .instr(instr),
    .opcode(opcode), .pc_out(pc_out), .instr_valid(instr_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = PH_START; m_pc = 32'h0; m_instr = 32'h0; m_pc_out = 32'h0;
    m_req = 1'b0; m_valid = 1'b0;
  endtask

  task automatic model_step();
    int   off;
    logic nreq, nvalid, tk;
    nreq = 1'b0; nvalid = 1'b0;
    if (m_phase == PH_START) begin
      m_phase = PH_MEM;
    end else if (m_phase == PH_MEM) begin
      if (m_req && imem_ready && !stall) begin
        m_instr = imem_rdata; m_pc_out = m_pc; nvalid = 1'b1; m_phase = PH_ISSUED;
      end else begin
        nreq = !stall;
      end
    end else if (m_phase == PH_ISSUED) begin
      m_phase = PH_EXEC;
    end else if (ex_done) begin
      tk  = branch && ((m_instr[31:26] == 6'd4 && zero) || (m_instr[31:26] == 6'd5 && !zero));
      off = $signed(m_instr[15:0]);
      m_pc = m_pc + 32'd4 + (tk ? 32'(off * 4) : 32'd0);
      m_phase = PH_MEM;
      nreq = !stall;
    end
    m_req = nreq; m_valid = nvalid;
  endtask

  always @(posedge clk) if (rst_n) model_step();
  always @(negedge rst_n) model_reset();

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
      chk("imem_addr", imem_addr, m_pc);
      chk("instr", instr, m_instr);
      chk("opcode", {26'd0, opcode}, {26'd0, m_instr[31:26]});
      chk("pc_out", pc_out, m_pc_out);
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    end
  end

  always @(posedge clk) begin
    #2;
    if (instr_valid === 1'b1) vcount++;
  end

  // One full fetch/issue/resolve; called and returning on a falling edge
  task automatic fetch_one(input logic [31:0] w, input logic br, input logic z,
                           input logic ex_in_issue, input int wait_extra,
                           input logic [31:0] exp_addr, output logic [31:0] addr);
    int k = 0;
    while (imem_req !== 1'b1 && k < 40) begin
      @(negedge clk); k++;
    end
    if (imem_req !== 1'b1) begin
      n_checks++;
      $display("FAIL fetch_timeout: imem_req=%b after %0d cycles, required 1", imem_req, k);
    end
    addr = imem_addr;
    chk("fetch_addr", addr, exp_addr);
    imem_ready = 1'b1; imem_rdata = w;
    @(negedge clk);
    imem_ready = 1'b0; imem_rdata = $urandom;
    ex_done = ex_in_issue; branch = br; zero = z;
    @(negedge clk);
    ex_done = 1'b0;
    for (int i = 0; i < wait_extra; i++) begin
      chk("wait_hold", imem_addr, exp_addr);
      @(negedge clk);
    end
    ex_done = 1'b1; branch = br; zero = z;
    @(negedge clk);
    ex_done = 1'b0; branch = 1'b0; zero = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; imem_ready = 1'b0; stall = 1'b0; ex_done = 1'b0; branch = 1'b0; zero = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic seq_to_10();
    for (int i = 0; i < 4; i++) fetch_one(32'h0, 1'b0, 1'b0, 1'b0, 0, 32'(i * 4), a);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_instr", instr, 32'h0);
    chk("reset_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_after_edge1", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("req_after_edge2", {31'd0, imem_req}, 32'd1);

    // Sequential R-type fetches, then beq taken from 0x10
    v0 = vcount;
    seq_to_10();
    chk("valid_pulses_seq", 32'(vcount - v0), 32'd4);
    fetch_one(32'h1000_0003, 1'b1, 1'b1, 1'b0, 0, 32'h10, a);
    chk("beq_target", imem_addr, 32'h20);

    // Wait states then stall at 0x20
    chk("stall_pre_req", {31'd0, imem_req}, 32'd1);
    v0 = vcount;
    repeat (2) @(negedge clk);
    @(negedge clk); stall = 1'b1;
    @(negedge clk); chk("stall_req_low1", {31'd0, imem_req}, 32'd0);
    @(negedge clk); chk("stall_req_low2", {31'd0, imem_req}, 32'd0); stall = 1'b0;
    chk("stall_no_capture", 32'(vcount - v0), 32'd0);
    fetch_one(32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h20, a);
    chk("stall_single_valid", 32'(vcount - v0), 32'd1);

    // Advance to 0x40 and reset asynchronously mid-fetch
    for (int i = 0; i < 7; i++) fetch_one(32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h24 + 32'(i * 4), a);
    chk("pre_reset_req", {31'd0, imem_req}, 32'd1);
    chk("pre_reset_addr", imem_addr, 32'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_addr", imem_addr, 32'h0);
    chk("async_instr", instr, 32'h0);
    chk("async_pc_out", pc_out, 32'h0);
    chk("async_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk); imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); imem_ready = 1'b0; rst_n = 1'b1;
    @(negedge clk); chk("no_capture_in_reset", instr, 32'h0);
    fetch_one(32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0, a);

    // bne not taken, then taken backwards
    do_reset();
    seq_to_10();
    fetch_one(32'h1400_FFFE, 1'b1, 1'b1, 1'b0, 0, 32'h10, a);
    chk("bne_not_taken", imem_addr, 32'h14);
    do_reset();
    seq_to_10();
    fetch_one(32'h1400_FFFE, 1'b1, 1'b0, 1'b0, 0, 32'h10, a);
    chk("bne_taken_back", imem_addr, 32'h0C);

    // Branch to 0xFFFFFFFC, wrap sequentially, with ex_done pulsed during issue
    do_reset();
    fetch_one(32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 0, 32'h0, a);
    chk("jump_to_top", imem_addr, 32'hFFFF_FFFC);
    fetch_one(32'h0, 1'b0, 1'b0, 1'b1, 2, 32'hFFFF_FFFC, a);
    chk("wrap_next", imem_addr, 32'h0);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      r = $urandom;
      case ($urandom % 4)
        0: imem_rdata = {6'b000100, r[25:0]};
        1: imem_rdata = {6'b000101, r[25:0]};
        2: imem_rdata = {6'b000000, r[25:0]};
        default: imem_rdata = r;
      endcase
      stall      = ($urandom % 4) == 0;
      imem_ready = ($urandom % 2) == 0;
      ex_done    = ($urandom % 3) == 0;
      branch     = ($urandom % 2) == 0;
      zero       = ($urandom % 2) == 0;
    end
    @(negedge clk);
    stall = 1'b0; imem_ready = 1'b0; ex_done = 1'b0; branch = 1'b0; zero = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
